// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access-size and
// FSM-state enums, the captured-request record and the alignment rule.
package dmem_responder_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_e;

    // Request as captured on the accepting edge and held until ACCESS.
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        mem_size_e       size;
        logic            is_unsigned;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // An access is aligned when the byte offset is a multiple of its size.
    function automatic logic is_misaligned(input logic [2:0] offset,
                                           input mem_size_e  size);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one doubleword: extracts and extends load data,
// and merges store bytes into the existing doubleword for read-modify-write.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [XLEN-1:0] old_dw,
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_val,
    output logic [XLEN-1:0] merged
);

    mem_size_e       sz;
    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic            sext;
    logic [7:0]      lane_mask;
    logic [7:0]      byte_mask;
    logic [XLEN-1:0] bit_mask;

    assign sz      = mem_size_e'(size);
    assign shamt   = {offset, 3'b000};
    assign shifted = old_dw >> shamt;
    assign sext    = ~is_unsigned;

    // Right-justify the selected lanes and extend from the top selected bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        load_val = shifted;
        case (sz)
            SZ_B:    load_val = {{56{sext & shifted[7]}},  shifted[7:0]};
            SZ_H:    load_val = {{48{sext & shifted[15]}}, shifted[15:0]};
            SZ_W:    load_val = {{32{sext & shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    // Lane enables for the access size; misaligned accesses never write,
    // so any lanes shifted off the top are irrelevant.
    always_comb begin
        lane_mask = 8'hFF;
        case (sz)
            SZ_B:    lane_mask = 8'h01;
            SZ_H:    lane_mask = 8'h03;
            SZ_W:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    end

    assign byte_mask = lane_mask << offset;

    // Expand byte enables to bit enables and merge the shifted store data.
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
        merged = (old_dw & ~bit_mask) | ((wdata << shamt) & bit_mask);
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, accesses a little-endian doubleword array and returns
// the result over a response handshake. All outputs are registered.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_e     state, state_d;
    logic [3:0]      cnt, cnt_d;
    logic            req_ready_d;
    logic            rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_d;
    logic            rsp_err_d;
    logic            capture;
    logic            mem_we;

    dmem_req_t       req_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [2:0]       offset;
    logic             out_of_range;
    logic             misaligned;
    logic             acc_err;
    logic [XLEN-1:0]  old_dw;
    logic [XLEN-1:0]  load_val;
    logic [XLEN-1:0]  merged;

    // Address decode of the captured request.
    assign idx          = req_q.addr[3 +: IDX_W];
    assign offset       = req_q.addr[2:0];
    assign out_of_range = |req_q.addr[XLEN-1:3+IDX_W];
    assign misaligned   = is_misaligned(offset, req_q.size);
    assign acc_err      = out_of_range | misaligned;
    assign old_dw       = mem[idx];

    dmem_lane_align u_lane_align (
        .old_dw      (old_dw),
        .offset      (offset),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .load_val    (load_val),
        .merged      (merged)
    );

    // Next-state and next-output logic for the request/response sequence.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        capture     = 1'b0;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    capture     = 1'b1;
                    req_ready_d = 1'b0;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_we      = req_q.we & ~acc_err;
                rsp_valid_d = 1'b1;
                rsp_err_d   = acc_err;
                rsp_rdata_d = (req_q.we || acc_err) ? '0 : load_val;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, registered outputs and captured request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before the edge.
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_q     <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            if (capture) begin
                req_q.we          <= req_we;
                req_q.addr        <= req_addr;
                req_q.size        <= mem_size_e'(req_size);
                req_q.is_unsigned <= req_unsigned;
                req_q.wdata       <= req_wdata;
            end
        end
    end

    // Array write; a store whose ACCESS edge meets reset assertion is dropped.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it can map onto RAM; its contents
        // survive reset and are undefined after power-up.
        if (mem_we && rst_n) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-level
// reference model. Instance A uses LATENCY = 2, instance B uses LATENCY = 0
// with rsp_ready tied high for back-to-back throughput.
module tb_dmem_responder;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;
    localparam int NB    = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance A signals
    logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0, a_req_unsigned = 1'b0;
    logic [63:0] a_req_addr = '0, a_req_wdata = '0, a_rsp_rdata;
    logic [1:0]  a_req_size = '0;
    logic        a_rsp_valid, a_rsp_ready = 1'b0, a_rsp_err;

    // Instance B signals
    logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0, b_req_unsigned = 1'b0;
    logic [63:0] b_req_addr = '0, b_req_wdata = '0, b_rsp_rdata;
    logic [1:0]  b_req_size = '0;
    logic        b_rsp_valid, b_rsp_err;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_size(a_req_size), .req_unsigned(a_req_unsigned),
        .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    int tests = 0;
    int fails = 0;

    logic [63:0] model_mem [2][DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed little-endian memory with size rules.
    function automatic void model_access(input int sel, input logic we,
                                         input logic [63:0] addr, input logic [1:0] size,
                                         input logic uns, input logic [63:0] wdata,
                                         output logic [63:0] rdata, output logic err);
        int n;
        int off;
        int idx;
        logic [63:0] dw;
        logic [63:0] val;
        n     = 1 << size;
        off   = int'(addr % 64'd8);
        rdata = '0;
        err   = ((addr >> 3) >= 64'(DEPTH)) || ((addr % 64'(n)) != 64'd0);
        if (err) return;
        idx = int'(addr >> 3);
        dw  = model_mem[sel][idx];
        val = '0;
        for (int i = 0; i < n; i++) begin
            if (we) dw[8*(off+i) +: 8] = wdata[8*i +: 8];
            else    val[8*i +: 8] = dw[8*(off+i) +: 8];
        end
        if (we) begin
            model_mem[sel][idx] = dw;
        end else begin
            if (!uns && n < 8 && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
            rdata = val;
        end
    endfunction

    // Present a request on A and wait for acceptance; returns #1 after the accept edge.
    task automatic send(input logic we, input logic [63:0] addr, input logic [1:0] size,
                        input logic uns, input logic [63:0] wdata);
        int n = 0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
        a_req_size = size; a_req_unsigned = uns; a_req_wdata = wdata;
        while (!a_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!a_req_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
    endtask

    // Wait for the response on A (counting edges since acceptance), then handshake.
    task automatic get_rsp(input bit early, output logic [63:0] rdata, output logic err);
        int k = 0;
        if (early) a_rsp_ready = 1'b1;
        do begin
            @(posedge clk);
            k++;
            #1;
        end while (!a_rsp_valid && k < 50);
        check("rsp_latency", 64'(k), 64'(LAT + 1));
        rdata = a_rsp_rdata;
        err   = a_rsp_err;
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(a_rsp_valid), 64'd0);
        check("req_ready_back", 64'(a_req_ready), 64'd1);
    endtask

    // Full transaction on A checked against the model.
    task automatic xact(input string tag, input logic we, input logic [63:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                        input bit early, output logic [63:0] rdata, output logic err);
        logic [63:0] exp_d;
        logic        exp_e;
        send(we, addr, size, uns, wdata);
        get_rsp(early, rdata, err);
        model_access(0, we, addr, size, uns, wdata, exp_d, exp_e);
        check({tag, "_rdata"}, rdata, exp_d);
        check({tag, "_err"}, 64'(err), 64'(exp_e));
    endtask

    initial begin
        logic [63:0] rd, exp_d, held_exp;
        logic        er, exp_e;
        int          k;
        logic [63:0] bl_addr [NB];
        logic [63:0] bl_wd   [NB];
        logic [1:0]  bl_size [NB];
        logic        bl_we   [NB];
        logic        bl_uns  [NB];
        logic [63:0] bq_d [$];
        logic        bq_e [$];
        int          bi, bgot, last_acc;

        // ---- reset values and release ----
        #2;
        check("rst_req_ready", 64'(a_req_ready), 64'd0);
        check("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
        check("rst_rsp_rdata", a_rsp_rdata, 64'd0);
        check("rst_rsp_err",   64'(a_rsp_err), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready_low", 64'(a_req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rel_req_ready_high", 64'(a_req_ready), 64'd1);

        // ---- initialise every doubleword of A with known data ----
        for (int i = 0; i < DEPTH; i++) begin
            xact("init", 1'b1, 64'(i * 8), 2'd3, 1'b0, {$urandom, $urandom}, 1'b0, rd, er);
        end

        // ---- directed cases ----
        xact("st_d", 1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, 1'b0, rd, er);
        check("st_d_zero", rd, 64'd0);
        xact("ld_d", 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 1'b0, rd, er);
        check("ld_d_lit", rd, 64'h1122334455667788);
        xact("st_b", 1'b1, 64'h13, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b1, rd, er);
        xact("ld_d2", 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 1'b0, rd, er);
        check("ld_d2_lit", rd, 64'h11223344AB667788);
        xact("ld_bs", 1'b0, 64'h13, 2'd0, 1'b0, 64'h0, 1'b1, rd, er);
        check("ld_bs_lit", rd, 64'hFFFFFFFFFFFFFFAB);
        xact("ld_bu", 1'b0, 64'h13, 2'd0, 1'b1, 64'h0, 1'b0, rd, er);
        check("ld_bu_lit", rd, 64'h00000000000000AB);
        xact("ld_w_mis", 1'b0, 64'h12, 2'd2, 1'b0, 64'h0, 1'b0, rd, er);
        check("ld_w_mis_err", 64'(er), 64'd1);
        xact("st_h_bad", 1'b1, 64'h401, 2'd1, 1'b0, 64'hBEEF, 1'b0, rd, er);
        check("st_h_bad_err", 64'(er), 64'd1);
        xact("st_h_oor", 1'b1, 64'h400, 2'd1, 1'b0, 64'hCAFE, 1'b0, rd, er);
        check("st_h_oor_err", 64'(er), 64'd1);
        xact("rb_idx0", 1'b0, 64'h0, 2'd3, 1'b0, 64'h0, 1'b0, rd, er);

        // ---- response stall with a held request ----
        send(1'b0, 64'h10, 2'd3, 1'b0, 64'h0);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            #1;
        end while (!a_rsp_valid && k < 50);
        check("stall_latency", 64'(k), 64'(LAT + 1));
        model_access(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, held_exp, exp_e);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 64'h18;
        a_req_size = 2'd3; a_req_unsigned = 1'b0; a_req_wdata = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 64'(a_rsp_valid), 64'd1);
            check("stall_rdata", a_rsp_rdata, held_exp);
            check("stall_req_ready", 64'(a_req_ready), 64'd0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b0;
        check("stall_hs_valid", 64'(a_rsp_valid), 64'd0);
        check("stall_hs_ready", 64'(a_req_ready), 64'd1);
        @(posedge clk);
        #1;
        check("held_accepted", 64'(a_req_ready), 64'd0);
        a_req_valid = 1'b0;
        get_rsp(1'b0, rd, er);
        model_access(0, 1'b0, 64'h18, 2'd3, 1'b0, 64'h0, exp_d, exp_e);
        check("held_rdata", rd, exp_d);

        // ---- reset during WAIT of a store ----
        send(1'b1, 64'h20, 2'd3, 1'b0, 64'hDEADBEEF_0BADF00D);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(a_rsp_valid), 64'd0);
        check("mid_rst_ready", 64'(a_req_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_valid_hold", 64'(a_rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready_low", 64'(a_req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rel_ready_high", 64'(a_req_ready), 64'd1);
        xact("after_rst_ld", 1'b0, 64'h20, 2'd3, 1'b0, 64'h0, 1'b0, rd, er);

        // ---- randomized traffic on A ----
        for (int t = 0; t < 150; t++) begin
            logic [1:0]  sz;
            logic [63:0] ad;
            int          off;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) off = $urandom_range(0, 7);
            else off = ($urandom_range(0, 7) >> sz) << sz;
            ad = 64'($urandom_range(0, DEPTH - 1)) * 64'd8 + 64'(off);
            if ($urandom_range(0, 19) == 0) ad = ad | (64'($urandom_range(1, 255)) << 10);
            if ($urandom_range(0, 39) == 0) ad = ad | 64'h8000_0000_0000_0000;
            xact("rand", 1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)), rd, er);
        end

        // ---- LATENCY = 0 back-to-back on B ----
        for (int i = 0; i < NB; i++) begin
            if (i < 6) begin
                bl_we[i] = 1'b1; bl_size[i] = 2'd3; bl_addr[i] = 64'(i * 8);
            end else begin
                int off;
                bl_we[i]   = 1'($urandom_range(0, 1));
                bl_size[i] = 2'($urandom_range(0, 3));
                off        = ($urandom_range(0, 7) >> bl_size[i]) << bl_size[i];
                bl_addr[i] = 64'($urandom_range(0, 5)) * 64'd8 + 64'(off);
            end
            bl_uns[i] = 1'($urandom_range(0, 1));
            bl_wd[i]  = {$urandom, $urandom};
        end
        bi = 0; bgot = 0; last_acc = 0;
        for (int cyc = 0; cyc < 300 && (bi < NB || bgot < NB); cyc++) begin
            @(negedge clk);
            if (b_rsp_valid) begin
                if (bgot < NB && bq_d.size() > 0) begin
                    check("b_rdata", b_rsp_rdata, bq_d.pop_front());
                    check("b_err", 64'(b_rsp_err), 64'(bq_e.pop_front()));
                end else begin
                    check("b_spurious_rsp", 64'd1, 64'd0);
                end
                bgot++;
            end
            if (bi < NB) begin
                b_req_valid = 1'b1; b_req_we = bl_we[bi]; b_req_addr = bl_addr[bi];
                b_req_size = bl_size[bi]; b_req_unsigned = bl_uns[bi]; b_req_wdata = bl_wd[bi];
                if (b_req_ready) begin
                    if (bi > 0) check("b_interval", 64'(cyc - last_acc), 64'd3);
                    last_acc = cyc;
                    model_access(1, bl_we[bi], bl_addr[bi], bl_size[bi], bl_uns[bi],
                                 bl_wd[bi], exp_d, exp_e);
                    bq_d.push_back(exp_d);
                    bq_e.push_back(exp_e);
                    bi++;
                end
            end else begin
                b_req_valid = 1'b0;
            end
        end
        b_req_valid = 1'b0;
        check("b_accept_count", 64'(bi), 64'(NB));
        check("b_rsp_count", 64'(bgot), 64'(NB));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name:
dmem_responder

Overview:
- Data-memory responder: the slave end of the load/store interface driven by the pipeline's memory-access stage.
- Accepts one request at a time over a valid/ready handshake and applies a programmable access latency.
- Performs byte, half, word or doubleword loads and stores on a little-endian, byte-addressed doubleword array. Loads are sign- or zero-extended.
- Returns a response (read data, or store acknowledge, plus error flag) over a second valid/ready handshake.

Parameters:
- DEPTH, 128: number of 64-bit doublewords in the array (power of 2).
- LATENCY, 2: wait cycles between request acceptance and array access (0..15).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_size  in  2  access size: 0 = B, 1 = H, 2 = W, 3 = D.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_wdata  in  64  store data, right-justified (lane 0 = bits 7:0).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  64  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0. Array contents are not reset.
- req_ready rises on the first posedge after rst_n deasserts.
- All outputs are registered.
- State machine:
  - IDLE: req_ready = 1. On req_valid & req_ready, capture we/addr/size/unsigned/wdata and drop req_ready. Go to WAIT with counter = LATENCY if LATENCY > 0, otherwise go directly to ACCESS.
  - WAIT: counter decrements each cycle. At 1, go to ACCESS.
  - ACCESS: single cycle. Perform the array read or write, load rsp_rdata/rsp_err, set rsp_valid, go to RESP.
  - RESP: hold rsp_valid/rsp_rdata/rsp_err stable until rsp_ready. On the handshake edge, clear rsp_valid, set req_ready, go to IDLE.
- Timing: request accepted at edge T → rsp_valid visible after edge T+LATENCY+1. No request overlap; peak throughput is one request per LATENCY+3 cycles.
- Addressing: index = addr[3+log2(DEPTH)-1:3], offset = addr[2:0].
- Error checks:
  - Out of range when addr[63:3] ≥ DEPTH.
  - Misaligned when offset is not a multiple of 2^size.
  - On error: no write, rsp_rdata = 0, rsp_err = 1.
- Loads: select 2^size bytes starting at byte lane offset. Sign-extend from the top selected bit unless unsigned; size 3 ignores unsigned.
- Stores: overwrite only the selected byte lanes with the low 2^size bytes of wdata; other lanes are unchanged (read-modify-write in the ACCESS cycle). Store response: rsp_rdata = 0, rsp_err = 0.
- Boundary conditions:
  - req_valid while not ready is ignored; the requester must hold it.
  - rsp_ready high before rsp_valid has no effect.
  - req_valid in RESP is not accepted until the edge after the response handshake.
- Reset mid-operation: the pending request is discarded and any store not yet in ACCESS is not performed. A store whose ACCESS edge coincides with reset assertion is not performed.

Decomposition:
- Shared package:
  - mem_size_e enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - dmem_state_e enum (IDLE, WAIT, ACCESS, RESP).
  - Request struct (we, addr, size, unsigned, wdata).
  - XLEN = 64 constant.
- One sub-module, dmem_lane_align: combinational byte-lane extract/sign-extend for loads and write-merge for stores. Inputs: old doubleword, offset, size, unsigned, wdata. Outputs: load value, merged doubleword.

Test Plan:
- Store D, addr 0x10, wdata 0x1122334455667788, then load D, addr 0x10 → rsp_rdata = 0x1122334455667788, rsp_err = 0. Each rsp_valid arrives LATENCY+1 cycles after acceptance.
- Over the above data, store B 0xAB at addr 0x13, then:
  - load D, addr 0x10 → 0x11223344AB667788.
  - load B signed, addr 0x13 → 0xFFFFFFFFFFFFFFAB.
  - load B unsigned, addr 0x13 → 0x00000000000000AB.
- Load W, addr 0x12 (misaligned) → rsp_err = 1, rsp_rdata = 0. Store H, addr 0x401 (misaligned and out of range for DEPTH = 128) → rsp_err = 1, array unchanged on readback.
- Hold rsp_ready = 0 for 5 cycles after rsp_valid → rsp_valid/rsp_rdata stable. req_valid held throughout is accepted only on the edge after the rsp handshake.
- Assert rst_n = 0 during WAIT of a store D, addr 0x20 → rsp_valid stays 0, req_ready = 0 during reset, then 1 one edge after release. A later load D of 0x20 returns the pre-store contents.
- LATENCY = 0 build: back-to-back requests with rsp_ready tied 1 → one accepted every 3 cycles, correct data on each.
